// File: rtl/multi_lane_conflict_detector_pkg.sv
// -----------------------------------------------------------------------------
// multi_lane_conflict_detector_pkg
// Shared types and helpers for the multi-lane implication conflict detector.
//   det_state_e : detector control states (ACTIVE / CONFLICT / BACKTRACK)
//   sat_add32   : 32-bit saturating add used by the optional statistics counters
// Table entry and index types depend on the detector parameters and are
// declared inside the top module.
// -----------------------------------------------------------------------------
package multi_lane_conflict_detector_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_CONFLICT  = 2'd1,
        ST_BACKTRACK = 2'd2
    } det_state_e;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/multi_lane_conflict_detector_lane_resolver.sv
// -----------------------------------------------------------------------------
// lane_resolver
// Combinational per-lane classification of incoming implications. Lanes are
// resolved in order 0..LANES-1; each lane sees the registered table entry for
// its variable plus any write made by a lower lane in the same cycle.
// Ports:
//   accept        in  LANES        lane carries an accepted implication
//   lane_var      in  LANES*VAR_W  lane variable indices (lane i at [i*VAR_W +: VAR_W])
//   lane_val      in  LANES        lane implied values
//   rd_assigned   in  LANES        table 'assigned' bit for each lane's variable
//   rd_value      in  LANES        table 'value' bit for each lane's variable
//   write         out LANES        lane writes a new assignment (and pushes it)
//   dup           out LANES        lane repeats an existing assignment
//   conflict_any  out 1            some lane contradicts an assignment
//   conflict_lane out LANE_W       lowest conflicting lane
//   conflict_var  out VAR_W        variable of the lowest conflicting lane
// -----------------------------------------------------------------------------
module lane_resolver #(
    parameter int NUM_VARS = 512,
    parameter int LANES    = 2,
    parameter int VAR_W    = 9,
    parameter int LANE_W   = 2
) (
    input  logic [LANES-1:0]       accept,
    input  logic [LANES*VAR_W-1:0] lane_var,
    input  logic [LANES-1:0]       lane_val,
    input  logic [LANES-1:0]       rd_assigned,
    input  logic [LANES-1:0]       rd_value,
    output logic [LANES-1:0]       write,
    output logic [LANES-1:0]       dup,
    output logic                   conflict_any,
    output logic [LANE_W-1:0]      conflict_lane,
    output logic [VAR_W-1:0]       conflict_var
);

    always_comb begin
        logic [VAR_W-1:0] vi;
        logic             hit;
        logic             hval;

        write         = '0;
        dup           = '0;
        conflict_any  = 1'b0;
        conflict_lane = '0;
        conflict_var  = '0;
        vi            = '0;
        hit           = 1'b0;
        hval          = 1'b0;

        for (int i = 0; i < LANES; i++) begin
            vi   = lane_var[i*VAR_W +: VAR_W];
            hit  = rd_assigned[i];
            hval = rd_value[i];
            // Forward same-cycle writes from lower lanes; they are not yet in the table.
            for (int j = 0; j < LANES; j++) begin
                if (j < i && write[j] && lane_var[j*VAR_W +: VAR_W] == vi) begin
                    hit  = 1'b1;
                    hval = lane_val[j];
                end
            end
            // Once a lane conflicts, every higher lane is discarded.
            if (accept[i] && !conflict_any && int'(vi) < NUM_VARS) begin
                if (hit) begin
                    if (hval == lane_val[i]) begin
                        dup[i] = 1'b1;
                    end else begin
                        conflict_any  = 1'b1;
                        conflict_lane = LANE_W'(i);
                        conflict_var  = vi;
                    end
                end else begin
                    write[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_lane_conflict_detector.sv
// -----------------------------------------------------------------------------
// multi_lane_conflict_detector
// Per-variable assignment table {assigned, value, level} checked against up to
// LANES implications per cycle. New assignments are reported as per-lane push
// enables for the imply stack; a contradiction raises a sticky conflict. A
// backtrack sweeps the table one entry per cycle, unassigning every variable
// whose level exceeds the latched target level.
// Optional feature: define CONFLICT_DETECTOR_STATS_EN to add saturating
// counters stat_accepts / stat_conflicts / stat_dups (cleared only by reset).
// Ports:
//   clock, reset (async, active-low)
//   en                 global enable for acceptance
//   imp_valid/var/val  per-lane implications, cur_level stamps accepted writes
//   imp_ready          comb: ACTIVE & en & ~bt_start
//   bt_start/bt_level  start a backtrack keeping levels <= bt_level
//   push_en/var/val    registered imply-stack pushes, one cycle after acceptance
//   conflict, conflict_var, conflict_lane  registered sticky conflict report
//   bt_busy, bt_done   sweep in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module multi_lane_conflict_detector
    import multi_lane_conflict_detector_pkg::*;
#(
    parameter int NUM_VARS = 512,
    parameter int LANES    = 2,
    parameter int LEVEL_W  = 9,
    localparam int VAR_W   = $clog2(NUM_VARS),
    localparam int LANE_W  = $clog2(LANES) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic [LANES-1:0]       imp_valid,
    input  logic [LANES*VAR_W-1:0] imp_var,
    input  logic [LANES-1:0]       imp_val,
    input  logic [LEVEL_W-1:0]     cur_level,
    output logic                   imp_ready,
    input  logic                   bt_start,
    input  logic [LEVEL_W-1:0]     bt_level,
    output logic [LANES-1:0]       push_en,
    output logic [LANES*VAR_W-1:0] push_var,
    output logic [LANES-1:0]       push_val,
    output logic                   conflict,
    output logic [VAR_W-1:0]       conflict_var,
    output logic [LANE_W-1:0]      conflict_lane,
    output logic                   bt_busy,
    output logic                   bt_done
`ifdef CONFLICT_DETECTOR_STATS_EN
    ,
    output logic [31:0]            stat_accepts,
    output logic [31:0]            stat_conflicts,
    output logic [31:0]            stat_dups
`endif
);

    typedef logic [VAR_W-1:0]   var_idx_t;
    typedef logic [LEVEL_W-1:0] level_t;
    typedef struct packed {
        logic   assigned;
        logic   value;
        level_t level;
    } assign_entry_t;

    localparam var_idx_t LAST_IDX = var_idx_t'(NUM_VARS - 1);

    det_state_e    state;
    assign_entry_t vtab [NUM_VARS];
    var_idx_t      sweep_idx;
    level_t        bt_lvl_q;

    var_idx_t          lane_var [LANES];
    logic [LANES-1:0]  accept;
    logic [LANES-1:0]  rd_assigned;
    logic [LANES-1:0]  rd_value;
    logic [LANES-1:0]  write;
    logic [LANES-1:0]  dup;
    logic              conflict_any;
    logic [LANE_W-1:0] res_lane;
    var_idx_t          res_var;

    assign imp_ready = (state == ST_ACTIVE) && en && !bt_start;
    assign accept    = imp_valid & {LANES{imp_ready}};

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_var[i]    = imp_var[i*VAR_W +: VAR_W];
            rd_assigned[i] = 1'b0;
            rd_value[i]    = 1'b0;
            if (int'(lane_var[i]) < NUM_VARS) begin
                rd_assigned[i] = vtab[lane_var[i]].assigned;
                rd_value[i]    = vtab[lane_var[i]].value;
            end
        end
    end

    lane_resolver #(
        .NUM_VARS (NUM_VARS),
        .LANES    (LANES),
        .VAR_W    (VAR_W),
        .LANE_W   (LANE_W)
    ) u_resolver (
        .accept        (accept),
        .lane_var      (imp_var),
        .lane_val      (imp_val),
        .rd_assigned   (rd_assigned),
        .rd_value      (rd_value),
        .write         (write),
        .dup           (dup),
        .conflict_any  (conflict_any),
        .conflict_lane (res_lane),
        .conflict_var  (res_var)
    );

    // Assignment table: lane writes while ACTIVE, one-entry-per-cycle clearing while sweeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_VARS; k++) begin
                vtab[k] <= '0;
            end
        end else if (state == ST_BACKTRACK) begin
            if (vtab[sweep_idx].level > bt_lvl_q) begin
                vtab[sweep_idx].assigned <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (write[i]) begin
                    vtab[lane_var[i]] <= '{assigned: 1'b1, value: imp_val[i], level: cur_level};
                end
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_ACTIVE;
            sweep_idx     <= '0;
            bt_lvl_q      <= '0;
            push_en       <= '0;
            push_var      <= '0;
            push_val      <= '0;
            conflict      <= 1'b0;
            conflict_var  <= '0;
            conflict_lane <= '0;
            bt_busy       <= 1'b0;
            bt_done       <= 1'b0;
        end else begin
            // write is already zero whenever nothing was accepted.
            push_en <= write;
            bt_done <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (write[i]) begin
                    push_var[i*VAR_W +: VAR_W] <= lane_var[i];
                    push_val[i]                <= imp_val[i];
                end
            end
            case (state)
                ST_ACTIVE, ST_CONFLICT: begin
                    if (bt_start) begin
                        bt_lvl_q  <= bt_level;
                        conflict  <= 1'b0;
                        sweep_idx <= '0;
                        bt_busy   <= 1'b1;
                        state     <= ST_BACKTRACK;
                    end else if (conflict_any) begin
                        conflict      <= 1'b1;
                        conflict_var  <= res_var;
                        conflict_lane <= res_lane;
                        state         <= ST_CONFLICT;
                    end
                end
                ST_BACKTRACK: begin
                    if (sweep_idx == LAST_IDX) begin
                        bt_busy <= 1'b0;
                        bt_done <= 1'b1;
                        state   <= ST_ACTIVE;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                default: state <= ST_ACTIVE;
            endcase
        end
    end

`ifdef CONFLICT_DETECTOR_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_accepts   <= '0;
            stat_conflicts <= '0;
            stat_dups      <= '0;
        end else begin
            stat_accepts   <= sat_add32(stat_accepts, 32'($countones(write)));
            stat_conflicts <= sat_add32(stat_conflicts, {31'd0, conflict_any});
            stat_dups      <= sat_add32(stat_dups, 32'($countones(dup)));
        end
    end
`else
    logic dup_unused;
    assign dup_unused = |dup;
`endif

endmodule

// File: tb/tb_multi_lane_conflict_detector.sv
// -----------------------------------------------------------------------------
// tb_multi_lane_conflict_detector
// Directed scenarios followed by randomized traffic, compared cycle by cycle
// against a behavioural model holding the assignment table as plain arrays.
// -----------------------------------------------------------------------------
module tb_multi_lane_conflict_detector;

    localparam int NV  = 16;
    localparam int LN  = 2;
    localparam int LW  = 4;
    localparam int VW  = 4;
    localparam int LNW = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic [LN-1:0]   imp_valid = '0;
    logic [LN*VW-1:0] imp_var = '0;
    logic [LN-1:0]   imp_val = '0;
    logic [LW-1:0]   cur_level = '0;
    logic            imp_ready;
    logic            bt_start = 1'b0;
    logic [LW-1:0]   bt_level = '0;
    logic [LN-1:0]   push_en;
    logic [LN*VW-1:0] push_var;
    logic [LN-1:0]   push_val;
    logic            conflict;
    logic [VW-1:0]   conflict_var;
    logic [LNW-1:0]  conflict_lane;
    logic            bt_busy;
    logic            bt_done;
`ifdef CONFLICT_DETECTOR_STATS_EN
    logic [31:0]     stat_accepts, stat_conflicts, stat_dups;
`endif

    multi_lane_conflict_detector #(
        .NUM_VARS (NV),
        .LANES    (LN),
        .LEVEL_W  (LW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .imp_valid     (imp_valid),
        .imp_var       (imp_var),
        .imp_val       (imp_val),
        .cur_level     (cur_level),
        .imp_ready     (imp_ready),
        .bt_start      (bt_start),
        .bt_level      (bt_level),
        .push_en       (push_en),
        .push_var      (push_var),
        .push_val      (push_val),
        .conflict      (conflict),
        .conflict_var  (conflict_var),
        .conflict_lane (conflict_lane),
        .bt_busy       (bt_busy),
        .bt_done       (bt_done)
`ifdef CONFLICT_DETECTOR_STATS_EN
        ,
        .stat_accepts   (stat_accepts),
        .stat_conflicts (stat_conflicts),
        .stat_dups      (stat_dups)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Behavioural model: mode 0 = accepting, 1 = conflicted, 2 = backtracking.
    bit       m_asg [NV];
    bit       m_val [NV];
    int       m_lvl [NV];
    int       m_mode;
    int       m_left;
    int       m_acc, m_conf, m_dup;
    bit       e_conflict;
    int       e_cvar, e_clane;
    bit [1:0] e_push;
    int       e_pvar [LN];
    bit       e_pval [LN];
    bit       e_busy, e_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NV; k++) begin
            m_asg[k] = 0; m_val[k] = 0; m_lvl[k] = 0;
        end
        m_mode = 0; m_left = 0;
        m_acc = 0; m_conf = 0; m_dup = 0;
        e_conflict = 0; e_cvar = 0; e_clane = 0;
        e_push = 0; e_busy = 0; e_done = 0;
        for (int i = 0; i < LN; i++) begin
            e_pvar[i] = 0; e_pval[i] = 0;
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, "_push_en"}, push_en, e_push);
        for (int i = 0; i < LN; i++) begin
            if (e_push[i]) begin
                check({ph, "_push_var"}, push_var[i*VW +: VW], e_pvar[i]);
                check({ph, "_push_val"}, push_val[i], e_pval[i]);
            end
        end
        check({ph, "_conflict"}, conflict, e_conflict);
        check({ph, "_conflict_var"}, conflict_var, e_cvar);
        check({ph, "_conflict_lane"}, conflict_lane, e_clane);
        check({ph, "_bt_busy"}, bt_busy, e_busy);
        check({ph, "_bt_done"}, bt_done, e_done);
    endtask

    // Reset asserted asynchronously a little after a clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge clock);
        #1;
        check_outputs("reset_hold");
        reset = 1'b1;
    endtask

    // One clock: drive inputs, check imp_ready, advance model, check registered outputs.
    task automatic cyc(input string ph, input logic e, input logic [1:0] v,
                       input logic [3:0] a0, input logic b0,
                       input logic [3:0] a1, input logic b1,
                       input logic [3:0] lv, input logic bs, input logic [3:0] bl);
        en = e; imp_valid = v; imp_var = {a1, a0}; imp_val = {b1, b0};
        cur_level = lv; bt_start = bs; bt_level = bl;
        #1;
        check({ph, "_imp_ready"}, imp_ready, (m_mode == 0 && e && !bs));
        e_push = 0;
        e_done = 0;
        if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 0; e_busy = 0; e_done = 1;
            end
        end else if (bs) begin
            for (int k = 0; k < NV; k++)
                if (m_lvl[k] > int'(bl)) m_asg[k] = 0;
            e_conflict = 0; m_mode = 2; m_left = NV; e_busy = 1;
        end else if (m_mode == 0 && e) begin
            for (int i = 0; i < LN; i++) begin
                int a;
                bit b;
                a = (i == 0) ? int'(a0) : int'(a1);
                b = (i == 0) ? b0 : b1;
                if (!v[i]) continue;
                if (m_asg[a]) begin
                    if (m_val[a] == b) m_dup++;
                    else begin
                        e_conflict = 1; e_cvar = a; e_clane = i; m_mode = 1; m_conf++;
                        break;
                    end
                end else begin
                    m_asg[a] = 1; m_val[a] = b; m_lvl[a] = int'(lv);
                    e_push[i] = 1; e_pvar[i] = a; e_pval[i] = b; m_acc++;
                end
            end
        end
        @(posedge clock);
        #1;
        check_outputs(ph);
    endtask

    task automatic sweep(input string ph);
        for (int k = 0; k < NV; k++) begin
            // Toggle en, keep lanes busy and retry bt_start: none may disturb the sweep.
            cyc(ph, logic'(k % 2), 2'b11, 4'(k), 1'b1, 4'd9, 1'b0, 4'd1, logic'(k == 3), 4'd0);
        end
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Two single-lane assignments
        cyc("t1a", 1, 2'b01, 4'd1, 0, 4'd0, 0, 4'd1, 0, 4'd0);
        cyc("t1b", 1, 2'b01, 4'd2, 1, 4'd0, 0, 4'd1, 0, 4'd0);

        // Conflict against the table, then stalled while conflicted
        cyc("t2", 1, 2'b01, 4'd1, 1, 4'd0, 0, 4'd1, 0, 4'd0);
        cyc("t2_hold", 1, 2'b11, 4'd6, 1, 4'd7, 0, 4'd1, 0, 4'd0);
        cyc("t2_bt", 1, 2'b00, 4'd0, 0, 4'd0, 0, 4'd1, 1, 4'd15);
        sweep("t2_sweep");

        // Intra-cycle conflict on lane 1: lane 0 still commits
        cyc("t3", 1, 2'b11, 4'd3, 1, 4'd3, 0, 4'd1, 0, 4'd0);
        cyc("t3_bt", 1, 2'b01, 4'd8, 0, 4'd0, 0, 4'd1, 1, 4'd15);
        sweep("t3_sweep");
        cyc("t3_dup", 1, 2'b01, 4'd3, 1, 4'd0, 0, 4'd1, 0, 4'd0);

        // Same variable and value on both lanes: lane 1 is a duplicate
        cyc("t4", 1, 2'b11, 4'd4, 1, 4'd4, 1, 4'd1, 0, 4'd0);

        // Backtrack to level 2 drops var5@3 and keeps var1@1
        cyc("t5a", 1, 2'b01, 4'd5, 1, 4'd0, 0, 4'd3, 0, 4'd0);
        cyc("t5_bt", 1, 2'b00, 4'd0, 0, 4'd0, 0, 4'd3, 1, 4'd2);
        sweep("t5_sweep");
        cyc("t5b", 1, 2'b11, 4'd5, 0, 4'd1, 0, 4'd2, 0, 4'd0);

        // Reset in the middle of a sweep
        cyc("t6_bt", 1, 2'b00, 4'd0, 0, 4'd0, 0, 4'd2, 1, 4'd0);
        for (int k = 0; k < 5; k++)
            cyc("t6_sweep", 1, 2'b00, 4'd0, 0, 4'd0, 0, 4'd2, 0, 4'd0);
        do_reset();
        cyc("t6", 1, 2'b01, 4'd1, 1, 4'd0, 0, 4'd1, 0, 4'd0);

        // Randomized traffic over a small variable range to force collisions
        for (int n = 0; n < 700; n++) begin
            logic       e, bs;
            logic [1:0] v;
            e  = ($urandom_range(0, 7) != 0);
            v  = 2'($urandom_range(0, 3));
            bs = ($urandom_range(0, 24) == 0) || (m_mode == 1 && $urandom_range(0, 3) == 0);
            cyc("rnd", e, v,
                4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), bs, 4'($urandom_range(0, 15)));
        end

`ifdef CONFLICT_DETECTOR_STATS_EN
        check("stat_accepts", stat_accepts, m_acc);
        check("stat_conflicts", stat_conflicts, m_conf);
        check("stat_dups", stat_dups, m_dup);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
